// File: rtl/memory_writer.sv
// memory_writer: turns an (addr, len) request into AXI4 INCR write bursts fed from a valid/ready stream.
// Define MEMORY_WRITER_BOUNDARY_SPLIT_EN to also cut bursts at 4 KiB address boundaries.
module memory_writer #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic [DATA_WIDTH-1:0]   din_data,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [LEN_WIDTH:0] MAX_B = (LEN_WIDTH + 1)'(MAX_BURST_LEN);
    localparam logic [LEN_WIDTH:0] ROUND = (LEN_WIDTH + 1)'(BYTES - 1);
    localparam logic [BYTES-1:0]   STRB_ONE = {{(BYTES - 1){1'b0}}, 1'b1};

    // state  | meaning
    // IDLE   | waiting for start
    // AW     | address of current burst offered
    // W      | streaming beats of current burst
    // B      | waiting for the burst write response
    // DONE   | one-cycle completion report
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

    state_t r_state, w_next_state;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [SIZE-1:0]       r_len_tail;
    logic [LEN_WIDTH:0]    r_rem;
    logic [8:0]            r_burst;
    logic [7:0]            r_awlen;
    logic [7:0]            r_wcnt;
    logic                  r_err;

    logic [LEN_WIDTH:0]    w_total;
    logic [LEN_WIDTH:0]    w_rem_after;
    logic [ADDR_WIDTH-1:0] w_addr_after;
    logic [LEN_WIDTH:0]    w_load_rem;
    logic [ADDR_WIDTH-1:0] w_load_addr;
    logic [8:0]            w_cap;
    logic [8:0]            w_load_burst;
    logic                  w_beat_last;
    logic                  w_xfer_last;
    logic                  w_w_fire;
    logic [BYTES-1:0]      w_tail_strb;
    logic                  w_unused;

    assign w_unused     = m_axi_bresp[0];
    assign w_total      = ({1'b0, len} + ROUND) >> SIZE;
    assign w_rem_after  = r_rem - (LEN_WIDTH + 1)'(r_burst);
    assign w_addr_after = r_addr + (ADDR_WIDTH'(r_burst) << SIZE);
    assign w_load_rem   = (r_state == S_IDLE) ? w_total : w_rem_after;
    assign w_load_addr  = (r_state == S_IDLE) ? addr : w_addr_after;
    assign w_cap        = (w_load_rem > MAX_B) ? MAX_B[8:0] : w_load_rem[8:0];

`ifdef MEMORY_WRITER_BOUNDARY_SPLIT_EN
    logic [12:0] w_to_bnd;
    assign w_to_bnd     = (13'h1000 - {1'b0, w_load_addr[11:0]}) >> SIZE;
    assign w_load_burst = ({4'b0, w_cap} > w_to_bnd) ? w_to_bnd[8:0] : w_cap;
`else
    assign w_load_burst = w_cap;
`endif

    assign w_beat_last = (r_wcnt == 8'd0);
    assign w_xfer_last = w_beat_last && (r_rem == (LEN_WIDTH + 1)'(r_burst));
    assign w_w_fire    = din_valid && m_axi_wready;
    // A zero tail means the last beat is full.
    assign w_tail_strb = (r_len_tail == '0) ? '1 : ((STRB_ONE << r_len_tail) - STRB_ONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = (len == '0) ? S_DONE : S_AW;
            S_AW:   if (m_axi_awready) w_next_state = S_W;
            S_W:    if (w_w_fire && w_beat_last) w_next_state = S_B;
            S_B:    if (m_axi_bvalid) w_next_state = (w_rem_after != '0) ? S_AW : S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_len_tail <= '0;
            r_rem      <= '0;
            r_burst    <= '0;
            r_awlen    <= '0;
            r_wcnt     <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_addr     <= addr;
                    r_len_tail <= len[SIZE-1:0];
                    r_rem      <= w_total;
                    r_burst    <= w_load_burst;
                    r_err      <= 1'b0;
                    if (len != '0) r_awlen <= 8'(w_load_burst - 9'd1);
                end
                S_AW: if (m_axi_awready) r_wcnt <= r_awlen;
                S_W:  if (w_w_fire && !w_beat_last) r_wcnt <= r_wcnt - 8'd1;
                S_B:  if (m_axi_bvalid) begin
                    r_err <= r_err | m_axi_bresp[1];
                    if (w_rem_after != '0) begin
                        r_rem   <= w_rem_after;
                        r_addr  <= w_addr_after;
                        r_burst <= w_load_burst;
                        r_awlen <= 8'(w_load_burst - 9'd1);
                    end
                end
                S_DONE: r_err <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy          = (r_state == S_AW) || (r_state == S_W) || (r_state == S_B);
        done          = (r_state == S_DONE);
        error         = (r_state == S_DONE) && r_err;
        m_axi_awaddr  = r_addr;
        m_axi_awlen   = r_awlen;
        m_axi_awsize  = 3'(SIZE);
        m_axi_awburst = 2'b01;
        m_axi_awvalid = (r_state == S_AW);
        m_axi_wdata   = din_data;
        m_axi_wvalid  = (r_state == S_W) && din_valid;
        din_ready     = (r_state == S_W) && m_axi_wready;
        m_axi_wlast   = (r_state == S_W) && w_beat_last;
        m_axi_wstrb   = '0;
        if (r_state == S_W) m_axi_wstrb = w_xfer_last ? w_tail_strb : '1;
        m_axi_bready  = (r_state == S_B);
    end

endmodule

// File: tb/tb_memory_writer.sv
// tb_memory_writer: table vectors, random transfers against a burst-list reference model, reset mid-W.
module tb_memory_writer;
    localparam int TMO = 3000;
    localparam int MAXB = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [15:0] len;
    logic        start;
    logic        busy, done, error;
    logic [63:0] din_data;
    logic        din_valid, din_ready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

    always #5 clock = ~clock;

    memory_writer #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .LEN_WIDTH(16), .MAX_BURST_LEN(MAXB)) dut (
        .clock(clock), .reset(reset), .addr(addr), .len(len), .start(start),
        .busy(busy), .done(done), .error(error),
        .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_t;
    typedef struct {
        logic [31:0] addr; logic [15:0] len; logic [7:0] resp;
        int exp_bursts; int exp_awlen0; logic exp_err;
    } vec_t;

    aw_t aw_q[$], exp_aw[$];
    w_t  w_q[$], exp_w[$];
    logic [63:0] src_data [0:63];
    int src_n, src_idx, b_idx;
    logic b_pend, src_fire, wl_fire, b_fire;
    logic cur_gaps;
    logic [7:0] cur_resp;
    int aw_valid_cnt, aw_unstable, err_out;
    logic busy_seen, aw_hold;
    logic [31:0] aw_prev_addr;
    logic [7:0]  aw_prev_len;
    int exp_lat, exp_beats;
    logic exp_err;
    int n_checks = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: split the request into bursts from the byte-level rules.
    task automatic model(input logic [31:0] a, input logic [15:0] l, input logic [7:0] rpk);
        int rem, b, k, widx, ad_lo;
        logic [31:0] ad;
        aw_t ea;
        w_t  ew;
        exp_aw.delete();
        exp_w.delete();
        exp_beats = (int'(l) + 7) / 8;
        rem = exp_beats; ad = a; k = 0; widx = 0; exp_err = 1'b0; exp_lat = 1;
        while (rem > 0) begin
            b = (rem < MAXB) ? rem : MAXB;
`ifdef MEMORY_WRITER_BOUNDARY_SPLIT_EN
            ad_lo = int'(ad[11:0]);
            if (b > (4096 - ad_lo) / 8) b = (4096 - ad_lo) / 8;
`else
            ad_lo = 0;
`endif
            ea.addr = ad; ea.len = 8'(b - 1);
            exp_aw.push_back(ea);
            for (int i = 0; i < b; i++) begin
                ew.data = src_data[widx];
                ew.strb = (widx == exp_beats - 1 && (l % 8) != 0) ? 8'((1 << (l % 8)) - 1) : 8'hFF;
                ew.last = (i == b - 1);
                exp_w.push_back(ew);
                widx++;
            end
            if (k < 4) exp_err = exp_err | rpk[2*k+1];
            exp_lat += b + 2;
            ad += 32'(b * 8);
            rem -= b;
            k++;
        end
    endtask

    task automatic monitor();
        aw_t ea;
        w_t  ew;
        if (m_axi_awvalid) aw_valid_cnt++;
        if (aw_hold && (m_axi_awaddr !== aw_prev_addr || m_axi_awlen !== aw_prev_len)) aw_unstable++;
        aw_hold = m_axi_awvalid && !m_axi_awready;
        aw_prev_addr = m_axi_awaddr;
        aw_prev_len  = m_axi_awlen;
        if (m_axi_awvalid && m_axi_awready) begin
            ea.addr = m_axi_awaddr; ea.len = m_axi_awlen;
            aw_q.push_back(ea);
            chk("awsize", 64'(m_axi_awsize), 64'd3);
            chk("awburst", 64'(m_axi_awburst), 64'd1);
        end
        if (m_axi_wvalid && m_axi_wready) begin
            ew.data = m_axi_wdata; ew.strb = m_axi_wstrb; ew.last = m_axi_wlast;
            w_q.push_back(ew);
        end
        src_fire = din_valid && din_ready;
        wl_fire  = m_axi_wvalid && m_axi_wready && m_axi_wlast;
        b_fire   = m_axi_bvalid && m_axi_bready;
        if (busy) busy_seen = 1'b1;
        if (error && !done) err_out++;
    endtask

    task automatic env_drive();
        if (src_fire) begin src_idx++; din_valid = 1'b0; end
        if (!din_valid && src_idx < src_n && (!cur_gaps || $urandom_range(0, 2) != 0)) begin
            din_valid = 1'b1;
            din_data  = src_data[src_idx];
        end
        m_axi_awready = cur_gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_axi_wready  = cur_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (b_fire) begin m_axi_bvalid = 1'b0; b_idx++; end
        if (wl_fire) b_pend = 1'b1;
        if (b_pend && !m_axi_bvalid && (!cur_gaps || $urandom_range(0, 1) == 1)) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (b_idx < 4) ? cur_resp[2*b_idx +: 2] : 2'b00;
            b_pend = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        env_drive();
    endtask

    task automatic prepare(input logic [31:0] a, input logic [15:0] l, input logic [7:0] r, input logic g);
        cur_gaps = g; cur_resp = r;
        src_n = (int'(l) + 7) / 8 + 2;
        for (int i = 0; i < src_n; i++) src_data[i] = {$urandom, $urandom};
        src_idx = 0; b_idx = 0; b_pend = 1'b0;
        m_axi_bvalid = 1'b0; din_valid = 1'b0;
        src_fire = 1'b0; wl_fire = 1'b0; b_fire = 1'b0;
        aw_q.delete(); w_q.delete();
        aw_valid_cnt = 0; aw_unstable = 0; err_out = 0; busy_seen = 1'b0; aw_hold = 1'b0;
        if (!g) begin din_valid = 1'b1; din_data = src_data[0]; end
        model(a, l, r);
        addr = a; len = l;
    endtask

    task automatic run_xfer(input logic [31:0] a, input logic [15:0] l, input logic [7:0] r,
                            input logic g, input logic xs,
                            output int nb, output int awlen0, output logic got_err);
        int lat, n;
        prepare(a, l, r, g);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < TMO) begin
            if (xs && busy && $urandom_range(0, 3) == 0) begin
                addr = $urandom & 32'h0000_FFF8;
                len  = 16'($urandom_range(1, 100));
                start = 1'b1;
            end
            step();
            start = 1'b0;
            lat++;
        end
        chk("done_seen", 64'(done), 64'd1);
        got_err = error;
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("error_at_done", 64'(error), 64'(exp_err));
        if (!g) chk("latency", 64'(lat), 64'(exp_lat));
        step();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("aw_count", 64'(aw_q.size()), 64'(exp_aw.size()));
        n = (aw_q.size() < exp_aw.size()) ? aw_q.size() : exp_aw.size();
        for (int i = 0; i < n; i++) begin
            chk("awaddr", 64'(aw_q[i].addr), 64'(exp_aw[i].addr));
            chk("awlen", 64'(aw_q[i].len), 64'(exp_aw[i].len));
        end
        chk("beat_count", 64'(w_q.size()), 64'(exp_w.size()));
        n = (w_q.size() < exp_w.size()) ? w_q.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk("wdata", w_q[i].data, exp_w[i].data);
            chk("wstrb", 64'(w_q[i].strb), 64'(exp_w[i].strb));
            chk("wlast", 64'(w_q[i].last), 64'(exp_w[i].last));
        end
        chk("stream_consumed", 64'(src_idx), 64'(exp_beats));
        chk("aw_stable", 64'(aw_unstable), 64'd0);
        chk("error_outside_done", 64'(err_out), 64'd0);
        if (l == 16'd0) begin
            chk("zero_len_busy", 64'(busy_seen), 64'd0);
            chk("zero_len_awvalid", 64'(aw_valid_cnt), 64'd0);
        end
        nb = aw_q.size();
        awlen0 = (aw_q.size() > 0) ? int'(aw_q[0].len) : -1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_done"}, 64'(done), 64'd0);
        chk({pfx, "_error"}, 64'(error), 64'd0);
        chk({pfx, "_awvalid"}, 64'(m_axi_awvalid), 64'd0);
        chk({pfx, "_wvalid"}, 64'(m_axi_wvalid), 64'd0);
        chk({pfx, "_wlast"}, 64'(m_axi_wlast), 64'd0);
        chk({pfx, "_bready"}, 64'(m_axi_bready), 64'd0);
        chk({pfx, "_din_ready"}, 64'(din_ready), 64'd0);
        chk({pfx, "_awaddr"}, 64'(m_axi_awaddr), 64'd0);
        chk({pfx, "_awlen"}, 64'(m_axi_awlen), 64'd0);
        chk({pfx, "_wstrb"}, 64'(m_axi_wstrb), 64'd0);
    endtask

    vec_t vecs [10];

    initial begin
        int nb, a0, guard;
        logic ge;
        logic [31:0] ra;
        logic [15:0] rl;

        vecs[0] = '{32'h0000_1000, 16'd0,   8'h00, 0, 0,  1'b0};
        vecs[1] = '{32'h0000_2000, 16'd64,  8'h00, 1, 7,  1'b0};
        vecs[2] = '{32'h0000_3000, 16'd13,  8'h00, 1, 1,  1'b0};
        vecs[3] = '{32'h0000_4000, 16'd256, 8'h02, 2, 15, 1'b1};
        vecs[4] = '{32'h0000_5000, 16'd8,   8'h00, 1, 0,  1'b0};
        vecs[5] = '{32'h0000_6000, 16'd200, 8'h0C, 2, 15, 1'b1};
        vecs[6] = '{32'h0000_7008, 16'd1,   8'h00, 1, 0,  1'b0};
        vecs[7] = '{32'h0000_8000, 16'd129, 8'h00, 2, 15, 1'b0};
`ifdef MEMORY_WRITER_BOUNDARY_SPLIT_EN
        vecs[8] = '{32'h0000_0FC0, 16'd128, 8'h00, 2, 7,  1'b0};
`else
        vecs[8] = '{32'h0000_0FC0, 16'd128, 8'h00, 1, 15, 1'b0};
`endif
        vecs[9] = '{32'h0000_9000, 16'd16,  8'h01, 1, 1,  1'b0};

        reset = 1'b1; start = 1'b0; addr = '0; len = '0;
        din_data = '0; din_valid = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        cur_gaps = 1'b0; cur_resp = 8'h00; src_n = 0; src_idx = 0; b_idx = 0; b_pend = 1'b0;
        src_fire = 1'b0; wl_fire = 1'b0; b_fire = 1'b0; aw_hold = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        step();
        check_reset_outputs("after_reset");

        for (int v = 0; v < 10; v++) begin
            run_xfer(vecs[v].addr, vecs[v].len, vecs[v].resp, 1'b0, 1'b0, nb, a0, ge);
            chk($sformatf("tbl%0d_bursts", v), 64'(nb), 64'(vecs[v].exp_bursts));
            if (vecs[v].exp_bursts > 0) chk($sformatf("tbl%0d_awlen0", v), 64'(a0), 64'(vecs[v].exp_awlen0));
            chk($sformatf("tbl%0d_err", v), 64'(ge), 64'(vecs[v].exp_err));
        end

        for (int t = 0; t < 14; t++) begin
            ra = $urandom & 32'h0000_FFF8;
            rl = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 400));
            run_xfer(ra, rl, 8'($urandom), 1'b1, 1'b1, nb, a0, ge);
        end

        prepare(32'h0000_A000, 16'd128, 8'h00, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (w_q.size() < 3 && guard < 100) begin step(); guard++; end
        chk("midw_reached", 64'(w_q.size() >= 3), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midw_reset");
        din_valid = 1'b0; m_axi_bvalid = 1'b0; b_pend = 1'b0;
        step();
        step();
        reset = 1'b0;
        run_xfer(32'h0000_B000, 16'd40, 8'h00, 1'b0, 1'b0, nb, a0, ge);
        chk("post_reset_bursts", 64'(nb), 64'd1);
        chk("post_reset_awlen", 64'(a0), 64'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/memory_writer.md
# memory_writer

Slave-side engine for the memory write handshake: accepts a byte address and length on `start`, pulls the payload from an upstream valid/ready data stream, and writes it to memory as one or more AXI4 INCR write bursts, reporting `busy`, `done` and `error` back to the requesting master. It sits between a packet-processing stage, which drives the master side, and the AXI interconnect toward DDR.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AXI and request address width.
- `DATA_WIDTH`, 64: AXI and stream data width; must be a power of two and at least 32.
- `LEN_WIDTH`, 16: width of the request length, in bytes.
- `MAX_BURST_LEN`, 16: maximum beats per AXI burst, 1..256.

Ports:
- `clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `addr`, in, ADDR_WIDTH: start byte address; must be aligned to DATA_WIDTH/8.
- `len`, in, LEN_WIDTH: transfer length in bytes.
- `start`, in, 1: request strobe.
- `busy`, out, 1: transfer in progress.
- `done`, out, 1: one-cycle completion pulse.
- `error`, out, 1: any burst got SLVERR/DECERR; valid only while `done`=1.
- `din_data`, in, DATA_WIDTH: payload stream data.
- `din_valid`, in, 1: payload stream valid.
- `din_ready`, out, 1: payload stream ready.
- `m_axi_aw*`, out/in: `awaddr` (ADDR_WIDTH), `awlen` (8), `awsize` (3), `awburst` (2), `awvalid`, `awready`.
- `m_axi_w*`, out/in: `wdata` (DATA_WIDTH), `wstrb` (DATA_WIDTH/8), `wlast`, `wvalid`, `wready`.
- `m_axi_b*`, in/out: `bresp` (2), `bvalid`, `bready`.

## Operation
- Let BYTES = DATA_WIDTH/8. Total beats = ceil(len/BYTES), computed in LEN_WIDTH+1 bits.
- States are IDLE, AW, W, B and DONE.
- IDLE: `start`=1 latches `addr`, `len` and the beat count, then moves to AW. If `len`=0, it moves to DONE instead and no AXI traffic occurs.
- AW:
  - Burst beats = min(remaining, MAX_BURST_LEN, beats to the next 4 KiB boundary; the last term applies only with the macro).
  - `awlen` = beats−1, `awsize` = log2(BYTES), `awburst` = INCR.
  - `awvalid` is held until `awready`, then the state moves to W.
- W: Pass-through with no buffering:
  - `wvalid` = `din_valid`, `din_ready` = `wready`, `wdata` = `din_data`.
  - `wlast` is asserted on the final beat of the burst.
  - `wstrb` is all ones, except on the final beat of the whole transfer, where it is the low (len mod BYTES) bits set, or all ones if that remainder is 0.
  - After the `wlast` handshake, the state moves to B.
- B: `bready`=1. On `bvalid`, `bresp[1]` is ORed into the sticky error. If beats remain, the address advances by beats×BYTES and the state returns to AW; otherwise it moves to DONE.
- DONE: `done`=1 and `error`=sticky for one cycle, then the state returns to IDLE and the sticky error clears.
- Only one burst is outstanding at a time. AW for burst n+1 is issued only after B for burst n.
- `start` while not in IDLE is ignored; no queuing.
- `din_ready`=0 outside W. Excess stream data beyond `len` is not consumed.

## Timing
- Reset values:
  - `busy`, `done`, `error`, `awvalid`, `wvalid`, `wlast`, `bready` and `din_ready` are 0.
  - `awaddr`, `awlen` and `wstrb` are 0.
  - State is IDLE.
- `start` is sampled at the clock edge. `busy`=1 and `awvalid`=1 from the next cycle.
- `busy` stays 1 through AW, W and B, and falls in the same cycle `done` rises.
- Zero length: `done` pulses exactly one cycle after `start`, and `busy` never rises.
- Back-to-back requests: a new `start` is accepted in the cycle after `done`.
- Minimum latency, `start` → `done` for one burst of N beats with zero-wait slaves: 1 (AW) + N (W) + 1 (B) + 1 (DONE) cycles.
- AXI valid/payload signals are stable from assertion until handshake.
- Reset mid-transfer forces IDLE immediately. AXI valids drop, which is acceptable only under a system-wide reset.

## Configuration
- `MEMORY_WRITER_BOUNDARY_SPLIT_EN` defined: bursts are also cut at 4 KiB address boundaries. The boundary computation uses `awaddr[11:0]`.
- Not defined: bursts are cut only at MAX_BURST_LEN. The master must guarantee that no burst crosses 4 KiB; the engine does not check this.

## Test plan
- `addr`=0x1000, `len`=0 → `done`=1 one cycle later with `error`=0; no `awvalid`.
- DATA_WIDTH=64, `addr`=0x2000, `len`=64 → one burst with `awlen`=7; 8 beats with `wstrb`=0xFF; `wlast` on beat 8; `done`, `error`=0.
- `len`=13 → `awlen`=1; beat-2 `wstrb`=0x1F.
- With the macro, `addr`=0xFC0, `len`=128 → two bursts: (0xFC0, `awlen`=7) and (0x1000, `awlen`=7).
- `len`=256, MAX_BURST_LEN=16 → two 16-beat bursts. First `bresp`=SLVERR (2'b10), second OKAY → `done` with `error`=1. The next request reports `error`=0.
- Random `din_valid`/`wready` gaps plus `start` pulses while busy → data matches the stream in order, and extra `start` pulses are ignored. Reset asserted mid-W → all outputs return to their reset values immediately.
